bzmusic_dp: RTL
===============

BZMUSIC_DP -- requirements
Module: bzmusic_dp

Interface
REQ-001 Parameter AW, default 8: music memory address width.
REQ-002 Parameter MUSIC_LEN, default 64: number of score words played, 1..2^AW-1.
REQ-003 Parameter BEAT_UNIT, default 12500: clk cycles per beat unit, >=1.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rstn  input  1  reset; asynchronous and active-low, the only asynchronous reset.
REQ-006 addr_en, addr_rstn  input  1 each  address counter increment / synchronous clear (active-low).
REQ-007 tune_en, tune_rstn  input  1 each  tune register load / synchronous clear (active-low).
REQ-008 beat_en, beat_rstn  input  1 each  beat register load / synchronous clear (active-low).
REQ-009 tune_pwm_en, tune_pwm_rstn  input  1 each  tone generator run / synchronous clear (active-low).
REQ-010 beat_cnt_en, beat_cnt_rstn  input  1 each  beat timer run / synchronous clear (active-low).
REQ-011 mem_addr  output  AW  score memory read address.
REQ-012 mem_rdata  input  16  score word, valid one cycle after mem_addr changes (synchronous-read memory).
REQ-013 tune_or_beat  output  1  type flag of current score word to the controller.
REQ-014 music_finish  output  1  last score word already played.
REQ-015 beat_finish  output  1  current note duration elapsed.
REQ-016 buzzer  output  1  square-wave drive to the buzzer.

Function
REQ-017 Score word format: bit15 = 1 tune word, 0 beat word; bits14:0 = value.
REQ-018 Tune value = half-period in clk cycles; 0 = rest (silence).
REQ-019 Beat value = note duration in BEAT_UNIT units.
REQ-020 Address counter addr (AW bits): addr_rstn=0 sets all-ones (priority over addr_en); else addr_en=1 increments, modulo 2^AW.
REQ-021 First increment after clear yields 0, so word 0 is the first word played.
REQ-022 mem_addr = addr, combinational.
REQ-023 tune_or_beat = mem_rdata[15], combinational, no register.
REQ-024 music_finish = (addr == MUSIC_LEN-1), combinational; low while addr is all-ones.
REQ-025 Tune register (15 bits): tune_rstn=0 clears (priority); else tune_en=1 loads mem_rdata[14:0]; else holds.
REQ-026 Beat register (15 bits): same rule using beat_rstn, beat_en.
REQ-027 Tone generator: tune_pwm_rstn=0 clears half-period counter and buzzer to 0 (priority).
REQ-028 Tone generator: tune_pwm_en=0 freezes counter and buzzer.
REQ-029 Tone generator: tune_pwm_en=1, tune reg=0 holds counter 0 and buzzer 0.
REQ-030 Tone generator: tune_pwm_en=1, tune reg=T>0: counter counts 0..T-1; at T-1 wraps to 0 and buzzer toggles; buzzer period = 2T cycles.
REQ-031 Beat timer: prescaler 0..BEAT_UNIT-1, unit counter increments on prescaler wrap.
REQ-032 Beat timer: beat_cnt_rstn=0 clears both (priority); beat_cnt_en=0 freezes both.
REQ-033 beat_finish = beat_cnt_en & (unit counter == beat reg), combinational.
REQ-034 While beat_finish is high, unit counter and prescaler hold (saturate), no wrap.
REQ-035 Beat reg=0: beat_finish rises in first cycle beat_cnt_en=1.
REQ-036 Controller timing: addr increments one cycle after controller ADD state; mem_rdata valid before JUDGE; latency: first buzzer edge T cycles after tune_pwm_en rises.

Reset
REQ-037 rstn=0: addr all-ones, tune reg, beat reg, tone counter, prescaler, unit counter, buzzer all 0.
REQ-038 Reset mid-note: buzzer falls immediately (asynchronous), no completion of note.
REQ-039 Synchronous clears (*_rstn inputs) take effect at next clk edge; never asynchronous.

Verification
REQ-040 Reset then addr_rstn=0 one cycle, addr_en pulse -> mem_addr 0, music_finish 0.
REQ-041 MUSIC_LEN=4, four addr_en pulses from cleared -> mem_addr 3, music_finish 1; fifth pulse -> mem_addr 4, music_finish 0.
REQ-042 mem_rdata=16'h8005, tune_en pulse, then tune_pwm_en=1 -> tune_or_beat 1; buzzer toggles every 5 cycles.
REQ-043 Tune reg=0, tune_pwm_en=1 for 100 cycles -> buzzer constant 0.
REQ-044 BEAT_UNIT=3, mem_rdata=16'h0002, beat_en pulse, beat_cnt_en=1 -> beat_finish high exactly 6 cycles later, stays high until beat_cnt_rstn=0.
REQ-045 rstn low mid-tone with buzzer=1 -> buzzer 0 same cycle; all registers at REQ-037 values.

Source files
------------

// File: rtl/bzmusic_dp.sv
// Buzzer music player datapath: score address counter, tune/beat registers,
// square-wave tone generator and beat-duration timer, sequenced by an external controller.
module bzmusic_dp #(
  parameter int AW        = 8,
  parameter int MUSIC_LEN = 64,
  parameter int BEAT_UNIT = 12500
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          addr_en,
  input  logic          addr_rstn,
  input  logic          tune_en,
  input  logic          tune_rstn,
  input  logic          beat_en,
  input  logic          beat_rstn,
  input  logic          tune_pwm_en,
  input  logic          tune_pwm_rstn,
  input  logic          beat_cnt_en,
  input  logic          beat_cnt_rstn,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_rdata,
  output logic          tune_or_beat,
  output logic          music_finish,
  output logic          beat_finish,
  output logic          buzzer
);

  localparam int            PW       = (BEAT_UNIT > 1) ? $clog2(BEAT_UNIT) : 1;
  localparam logic [AW-1:0] LAST_ADR = AW'(MUSIC_LEN - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(BEAT_UNIT - 1);

  logic [AW-1:0] r_addr;
  logic [14:0]   r_tune;
  logic [14:0]   r_beat;
  logic [14:0]   r_tone_cnt;
  logic          r_buzzer;
  logic [PW-1:0] r_presc;
  logic [14:0]   r_units;
  logic          w_beat_finish;
  logic          w_tone_wrap;

  // Cleared address is all-ones so the first increment selects word 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_addr <= '1;
    end else if (!addr_rstn) begin
      r_addr <= '1;
    end else if (addr_en) begin
      r_addr <= r_addr + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      r_addr <= r_addr;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tune <= 15'd0;
      r_beat <= 15'd0;
    end else begin
      if (!tune_rstn)   r_tune <= 15'd0;
      else if (tune_en) r_tune <= mem_rdata[14:0];
      else              r_tune <= r_tune;
      if (!beat_rstn)   r_beat <= 15'd0;
      else if (beat_en) r_beat <= mem_rdata[14:0];
      else              r_beat <= r_beat;
    end
  end

  // >= rather than == so a shorter tune loaded mid-phase still wraps.
  assign w_tone_wrap = (r_tone_cnt >= (r_tune - 15'd1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tone_cnt <= 15'd0;
      r_buzzer   <= 1'b0;
    end else if (!tune_pwm_rstn) begin
      r_tone_cnt <= 15'd0;
      r_buzzer   <= 1'b0;
    end else if (!tune_pwm_en) begin
      r_tone_cnt <= r_tone_cnt;
      r_buzzer   <= r_buzzer;
    end else if (r_tune == 15'd0) begin
      r_tone_cnt <= 15'd0;
      r_buzzer   <= 1'b0;
    end else if (w_tone_wrap) begin
      r_tone_cnt <= 15'd0;
      r_buzzer   <= ~r_buzzer;
    end else begin
      r_tone_cnt <= r_tone_cnt + 15'd1;
      r_buzzer   <= r_buzzer;
    end
  end

  assign w_beat_finish = beat_cnt_en & (r_units == r_beat);

  // Timer saturates once the note duration is reached until cleared.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_presc <= '0;
      r_units <= 15'd0;
    end else if (!beat_cnt_rstn) begin
      r_presc <= '0;
      r_units <= 15'd0;
    end else if (!beat_cnt_en || w_beat_finish) begin
      r_presc <= r_presc;
      r_units <= r_units;
    end else if (r_presc == PRE_MAX) begin
      r_presc <= '0;
      r_units <= r_units + 15'd1;
    end else begin
      r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
      r_units <= r_units;
    end
  end

  assign mem_addr     = r_addr;
  assign tune_or_beat = mem_rdata[15];
  assign music_finish = (r_addr == LAST_ADR);
  assign beat_finish  = w_beat_finish;
  assign buzzer       = r_buzzer;

endmodule
